// File: rtl/spike_frame_sender.sv
// spike_frame_sender: buffers a T_STEPS-deep spike frame and streams it to a
// layer-norm consumer, then waits (with timeout) for the consumer's done level.
module spike_frame_sender #(
    parameter int T_STEPS = 30,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic [2:0]       block_id,
    input  logic             ln_done,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    output logic [2:0]       tx_block_sel,
    output logic             busy,
    output logic             finished,
    output logic [1:0]       err
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, FIN} state_t;
    localparam logic [4:0] LAST_STEP = 5'(T_STEPS - 1);
    localparam logic [6:0] LAST_WAIT = 7'(TIMEOUT - 1);
    state_t state, state_nx;
    logic [WIDTH-1:0] buffer [T_STEPS];
    logic [4:0] step;
    logic [6:0] wcnt;
    logic wr_ok, last_step, drained_done, timed_out;
    assign busy         = state != IDLE;
    assign tx_valid     = state == SEND;
    assign finished     = state == FIN;
    assign wr_ok        = wr_en && !busy && wr_addr <= LAST_STEP;
    assign last_step    = step == LAST_STEP;
    // The first two WAIT_DONE cycles let the consumer drain before ln_done counts.
    assign drained_done = wcnt >= 7'd2 && ln_done;
    assign timed_out    = wcnt == LAST_WAIT;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = start ? SEND : IDLE;
            SEND:      state_nx = last_step ? WAIT_DONE : SEND;
            WAIT_DONE: state_nx = (drained_done || timed_out) ? FIN : WAIT_DONE;
            default:   state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < T_STEPS; i++) buffer[i] <= '0;
            tx_data      <= '0;
            tx_block_sel <= '0;
            step         <= '0;
            wcnt         <= '0;
            err          <= '0;
        end else begin
            if (wr_ok) buffer[wr_addr] <= wr_data;
            if (wr_en && busy) err[0] <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    tx_block_sel <= block_id;
                    step         <= '0;
                    // Forward a same-cycle write to step 0 so it joins this frame.
                    tx_data      <= (wr_ok && wr_addr == 5'd0) ? wr_data : buffer[0];
                end
                SEND: if (last_step) begin
                    tx_data <= '0;
                    wcnt    <= '0;
                end else begin
                    step    <= step + 5'd1;
                    tx_data <= buffer[step + 5'd1];
                end
                WAIT_DONE: begin
                    wcnt <= (wcnt == 7'h7f) ? wcnt : wcnt + 7'd1;
                    if (timed_out && !drained_done) err[1] <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spike_frame_sender.sv
// tb_spike_frame_sender: randomized frames checked by a queue scoreboard and a
// frame-level reference model of buffer contents, errors and handshake timing.
module tb_spike_frame_sender;
    localparam int T = 30, W = 16, TO = 64;
    logic clk = 0, rst_n = 0, wr_en = 0, start = 0, ln_done = 0;
    logic [4:0] wr_addr = 0;
    logic [W-1:0] wr_data = 0;
    logic [2:0] block_id = 0;
    logic [W-1:0] tx_data;
    logic tx_valid, busy, finished;
    logic [2:0] tx_block_sel;
    logic [1:0] err;
    int n_cmp = 0, n_bad = 0;
    logic [W-1:0] mbuf [T];
    logic [1:0] merr = 0;
    logic [W+2:0] q [$];

    spike_frame_sender #(.T_STEPS(T), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .block_id(block_id), .ln_done(ln_done), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_block_sel(tx_block_sel), .busy(busy),
        .finished(finished), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [W+2:0] e;
        if (rst_n) begin
            if (tx_valid) begin
                if (q.size() == 0) chk("unexpected_valid", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("tx_data", tx_data, e[W-1:0]);
                    chk("tx_block_sel", tx_block_sel, e[W+2:W]);
                end
            end else chk("idle_data_zero", tx_data, 0);
        end
    end

    task automatic wr(input logic [4:0] a, input logic [W-1:0] v);
        wr_en = 1; wr_addr = a; wr_data = v;
        if (a < T) mbuf[a] = v;
        tick();
        wr_en = 0;
    endtask

    // d: WAIT_DONE cycle index from which ln_done is held high
    task automatic frame(input int d, input bit noise, input bit start_wr, input logic [2:0] sel);
        int cnt, e;
        start = 1; block_id = sel;
        if (start_wr) begin
            wr_en = 1; wr_addr = 5'($urandom_range(0, T-1)); wr_data = W'($urandom);
            mbuf[wr_addr] = wr_data;
        end
        for (int k = 0; k < T; k++) q.push_back({sel, mbuf[k]});
        tick();
        start = 0; wr_en = 0; block_id = 3'($urandom);
        chk("busy_after_start", busy, 1);
        for (int j = 0; j < T; j++) begin
            if (noise) begin
                start = $urandom_range(0, 3) == 0;
                wr_en = $urandom_range(0, 3) == 0;
                if (wr_en) begin
                    wr_addr = 5'($urandom_range(0, T-1)); wr_data = W'($urandom);
                    merr[0] = 1;
                end
            end
            tick();
        end
        start = 0; wr_en = 0;
        chk("valid_dropped", tx_valid, 0);
        chk("frame_len_left", q.size(), 0);
        e = (d > TO-1) ? TO-1 : (d < 2 ? 2 : d);
        if (d > TO-1) merr[1] = 1;
        cnt = 0;
        do begin
            ln_done = cnt >= d;
            tick();
            cnt++;
        end while (!finished && cnt < 200);
        ln_done = 0;
        chk("done_latency", cnt, e + 1);
        chk("err", err, merr);
        chk("busy_in_fin", busy, 1);
        tick();
        chk("busy_idle", busy, 0);
        chk("fin_pulse_width", finished, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int d;
        for (int k = 0; k < T; k++) mbuf[k] = 0;
        tick(); tick();
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_sel", tx_block_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_finished", finished, 0);
        chk("rst_err", err, 0);
        rst_n = 1;
        tick();
        for (int k = 0; k < T; k++) wr(5'(k), W'(k + 1));
        frame(2, 0, 0, 3'd3);
        wr(5'd31, 16'hdead);
        chk("err_after_oob_write", err, 0);
        frame(1000, 0, 0, 3'd6);
        frame(5, 1, 1, 3'd1);
        for (int f = 0; f < 20; f++) begin
            repeat ($urandom_range(0, 6)) wr(5'($urandom_range(0, 31)), W'($urandom));
            case ($urandom_range(0, 3))
                0: d = $urandom_range(0, 4);
                1: d = $urandom_range(5, 40);
                2: d = $urandom_range(60, 66);
                default: d = 1000;
            endcase
            frame(d, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 3'($urandom));
        end
        start = 1; block_id = 3'd5;
        for (int k = 0; k < T; k++) q.push_back({3'd5, mbuf[k]});
        tick();
        start = 0;
        repeat (9) tick();
        chk("tenth_valid", tx_valid, 1);
        rst_n = 0;
        #1;
        chk("arst_tx_valid", tx_valid, 0);
        chk("arst_tx_data", tx_data, 0);
        chk("arst_sel", tx_block_sel, 0);
        chk("arst_busy", busy, 0);
        chk("arst_finished", finished, 0);
        chk("arst_err", err, 0);
        q.delete();
        for (int k = 0; k < T; k++) mbuf[k] = 0;
        merr = 0;
        tick(); tick();
        rst_n = 1;
        tick(); tick();
        chk("no_valid_after_reset", tx_valid, 0);
        frame(3, 0, 0, 3'd4);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
